// File: rtl/sync_event_arbiter_if.sv
// Event port bundle for sync_event_arbiter.
//   ev_valid : producer -> consumer, an event id is presented
//   ev_id    : producer -> consumer, index of the presented requester
//   ev_ready : consumer -> producer, accepts the presented event
// The master modport is the arbiter side and the slave modport is the consumer side.
interface sync_event_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) ();
  logic           ev_valid;
  logic [IDW-1:0] ev_id;
  logic           ev_ready;

  modport master (output ev_valid, output ev_id, input ev_ready);
  modport slave  (input ev_valid, input ev_id, output ev_ready);
endinterface

// File: rtl/sync_event_arbiter.sv
// sync_event_arbiter: synchronizes N asynchronous event lines, detects their
// rising edges, and holds each edge as a pending event. All pending events
// share one registered valid/ready event port, which is served round-robin.
//
// Ports:
//   clk_i          sole clock, rising edge
//   rst_i          synchronous active-high reset
//   req_async_i    N asynchronous event lines, bit i = requester i
//   clr_overflow_i clears all sticky overflow bits
//   pending_o      registered pending flags (status)
//   overflow_o     sticky: edge arrived while that requester was already pending
//   ev_if          event port (master side): ev_valid/ev_id out, ev_ready in
module sync_event_arbiter #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 3,
  parameter int IDW         = $clog2(N)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_async_i,
  input  logic                 clr_overflow_i,
  output logic [N-1:0]         pending_o,
  output logic [N-1:0]         overflow_o,
  sync_event_arbiter_if.master ev_if
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [N-1:0]   sync_q [SYNC_STAGES];
  logic [N-1:0]   prev_q;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   overflow_q, overflow_d;
  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] rr_q, rr_d;

  logic [N-1:0]   edge_s;
  logic [N-1:0]   clr_mask_s;
  logic [N-1:0]   ovf_new_s;
  logic           xfer_s;
  logic           load_s;
  logic           found_s;
  logic [IDW-1:0] sel_s;
  logic [IDW-1:0] rr_next_s;
  logic [IDW:0]   sum_s;
  logic [IDW-1:0] idx_s;

  // Synchronizer chain plus one history flop per line; the last stage feeds edge detect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= req_async_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_s = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign xfer_s = (state_q == ST_FULL) && ev_if.ev_ready;
  // A new event may enter the output register when it is empty or emptying now.
  assign load_s = (|pending_q) && ((state_q == ST_EMPTY) || xfer_s);

  // Round-robin search: first pending index at or after rr_q, wrapping to 0.
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    sum_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, rr_q} + (IDW+1)'(k);
      if (sum_s >= (IDW+1)'(N)) begin
        sum_s = sum_s - (IDW+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[IDW-1:0];
      if (!found_s && pending_q[idx_s]) begin
        found_s = 1'b1;
        sel_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign rr_next_s = (sel_s == IDW'(N - 1)) ? '0 : sel_s + IDW'(1);

  // Pending/overflow next state; a same-cycle edge re-sets the bit being cleared.
  always_comb begin
    clr_mask_s = '0;
    if (load_s) begin
      clr_mask_s[sel_s] = 1'b1;
    end else begin
      clr_mask_s = '0;
    end
    ovf_new_s = edge_s & pending_q & ~clr_mask_s;
    pending_d = (pending_q & ~clr_mask_s) | edge_s;
    if (clr_overflow_i) begin
      overflow_d = ovf_new_s;
    end else begin
      overflow_d = overflow_q | ovf_new_s;
    end
  end

  // Output register state machine: EMPTY/FULL with id held stable while FULL.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    case (state_q)
      ST_EMPTY: begin
        if (load_s) begin
          state_d = ST_FULL;
          id_d    = sel_s;
          rr_d    = rr_next_s;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (load_s) begin
          state_d = ST_FULL;
          id_d    = sel_s;
          rr_d    = rr_next_s;
        end else if (xfer_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      overflow_q <= '0;
      state_q    <= ST_EMPTY;
      id_q       <= '0;
      rr_q       <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      id_q       <= id_d;
      rr_q       <= rr_d;
    end
  end

  assign ev_if.ev_valid = state_q[0];
  assign ev_if.ev_id    = id_q;
  assign pending_o      = pending_q;
  assign overflow_o     = overflow_q;

endmodule
